bram_dwc_down: RTL and testbench
================================

Name: bram_dwc_down

Overview:
- Wide-to-narrow BRAM data width converter: a wide master issues one request, and the block serialises it into RATIO consecutive narrow BRAM port accesses.
- This is the direction that needs handshaking and buffering. The master side therefore uses a req/gnt + response-valid handshake instead of a plain BRAM port.
- Sits between a wide datapath (e.g. 96-bit engine) and a narrow 32-bit BRAM. The BRAM side is clocked by Clk_C.

Parameters:
- ADDR_BITW, 32, byte-address width on both sides.
- MST_DATA_BITW, 96, wide master data width; integer multiple of SLV_DATA_BITW.
- SLV_DATA_BITW, 32, narrow BRAM data width; multiple of 8.
- Derived: RATIO = MST_DATA_BITW/SLV_DATA_BITW.
- Derived: MST_BYTEW = MST_DATA_BITW/8; SLV_BYTEW = SLV_DATA_BITW/8.
- Derived: MST_BITO = ceil(log2(MST_BYTEW)); SLV_BITO = log2(SLV_BYTEW).
- Elaboration: $fatal if SLV_DATA_BITW > MST_DATA_BITW, or the widths are not multiples as stated above.

Ports:
- Clk_C  in  1  clock; all logic on rising edge.
- Rst_R  in  1  synchronous, active-high reset.
- Req_S  in  1  master request valid.
- Gnt_S  out  1  request accepted when Req_S&&Gnt_S at a rising edge.
- Addr_S  in  ADDR_BITW  byte address of wide word; bits below MST_BITO ignored.
- We_S  in  1  1 = write, 0 = read.
- WrEn_S  in  MST_BYTEW  write byte enables.
- Wr_D  in  MST_DATA_BITW  write data.
- RspValid_S  out  1  one-cycle completion pulse (reads and writes).
- Rd_D  out  MST_DATA_BITW  assembled read data, registered.
- Bram_En_S  out  1  narrow BRAM enable.
- Bram_Addr_S  out  ADDR_BITW  narrow BRAM byte address.
- Bram_WrEn_S  out  SLV_BYTEW  narrow BRAM byte write enables.
- Bram_Wr_D  out  SLV_DATA_BITW  narrow BRAM write data.
- Bram_Rd_D  in  SLV_DATA_BITW  narrow BRAM read data, 1-cycle latency after Bram_En_S.

Behaviour:
- States:
  - IDLE: Gnt_S=1. On Req_S, latch Addr_S/We_S/WrEn_S/Wr_D, clear beat counter k, go to ACCESS.
  - ACCESS: RATIO cycles, k=0..RATIO-1. Bram_En_S=1.
    - Bram_Addr_S = ((Addr_S>>MST_BITO)*RATIO + k) << SLV_BITO, truncated to ADDR_BITW.
    - Write: Bram_Wr_D = Wr_D slice k (bits k*SLV+:SLV); Bram_WrEn_S = WrEn_S slice k.
    - Read: Bram_WrEn_S=0.
    - After k=RATIO-1, go to WAIT.
  - WAIT: one cycle; Bram_En_S=0; go to RESP.
  - RESP: RspValid_S=1 for one cycle; go to IDLE.
- Read capture: Bram_Rd_D for beat k is sampled into Rd_D slice k one cycle after beat k issues. The last slice is therefore captured at the end of WAIT.
- Rd_D updates only on read slices and holds its value otherwise; writes never modify it.
- Outside ACCESS: Bram_En_S=0, Bram_WrEn_S=0, Bram_Wr_D=0. Bram_Addr_S holds its last value (0 after reset).
- Gnt_S=0 in ACCESS/WAIT/RESP; requests there are not accepted (Req_S is ignored).
- Latency: accept at edge ending cycle T; beats in T+1..T+RATIO; RspValid_S in T+RATIO+2.
- Throughput: one request per RATIO+3 cycles.
- Reset values: state IDLE, Gnt_S=1, RspValid_S=0, Rd_D=0, all Bram_* outputs 0.
- Reset mid-operation: next cycle returns to IDLE with Bram_En_S=0 and Rd_D=0. No RspValid_S for the aborted request; narrow writes already issued stay in the BRAM.
- Address wrap: the narrow address computation wraps modulo 2^ADDR_BITW; no error is flagged.

Optional Feature:
- Macro: BRAM_DWC_DOWN_SKIP_EN.
- Defined: a write beat whose WrEn_S slice is all-zero drives Bram_En_S=0 for that beat, saving power. Timing is unchanged, with k still advancing.
- Undefined: Bram_En_S=1 on every ACCESS beat.
- Reads are unaffected either way.

Test Plan (defaults, RATIO=3, MST_BITO=4, SLV_BITO=2):
1. Full write: Addr_S=0x20, Wr_D=0xCCCCCCCC_BBBBBBBB_AAAAAAAA, WrEn_S=0xFFF, accepted at T.
   - Required: beats T+1..T+3 drive Bram_Addr_S 0x18/0x1C/0x20, Bram_Wr_D AAAAAAAA/BBBBBBBB/CCCCCCCC, Bram_WrEn_S 0xF each.
   - Required: RspValid_S=1 only at T+5; Gnt_S=0 T+1..T+5.
2. Read-back of 0x20 -> Bram_WrEn_S=0, Rd_D=0xCCCCCCCC_BBBBBBBB_AAAAAAAA at RspValid_S (T+5); Rd_D unchanged afterwards.
3. Partial write, WrEn_S=0x0F0 -> beat 1 WrEn 0xF; beats 0 and 2 WrEn 0.
   - Macro off: Bram_En_S=1 on all beats.
   - Macro on: Bram_En_S=0 on beats 0 and 2.
4. Back-to-back: Req_S held high for two reads -> second accepted at T+6, second RspValid_S at T+11.
5. Rst_R=1 during beat k=1 -> next cycle Bram_En_S=0, Gnt_S=1, Rd_D=0; no RspValid_S ever appears for that request.
6. Unaligned address: Addr_S=0x2C -> identical Bram_Addr_S sequence to Addr_S=0x20 (0x18/0x1C/0x20).

Source files
------------

// File: rtl/bram_dwc_down_if.sv
// Wide master request/response bus for bram_dwc_down.
// The master issues one wide request (Req_S/Gnt_S handshake) and receives
// a one-cycle RspValid_S pulse with the assembled read data on Rd_D.
interface bram_dwc_down_if #(
    parameter int ADDR_BITW     = 32,
    parameter int MST_DATA_BITW = 96
);
    localparam int MST_BYTEW = MST_DATA_BITW / 8;

    logic                     Req_S;
    logic                     Gnt_S;
    logic [ADDR_BITW-1:0]     Addr_S;
    logic                     We_S;
    logic [MST_BYTEW-1:0]     WrEn_S;
    logic [MST_DATA_BITW-1:0] Wr_D;
    logic                     RspValid_S;
    logic [MST_DATA_BITW-1:0] Rd_D;

    // Wide requester side.
    modport master (
        output Req_S, Addr_S, We_S, WrEn_S, Wr_D,
        input  Gnt_S, RspValid_S, Rd_D
    );

    // Converter side.
    modport slave (
        input  Req_S, Addr_S, We_S, WrEn_S, Wr_D,
        output Gnt_S, RspValid_S, Rd_D
    );
endinterface

// File: rtl/bram_dwc_down.sv
// Wide-to-narrow BRAM data width converter.
// One wide request is serialised into RATIO consecutive narrow BRAM beats,
// followed by a one-cycle wait for the last read word and a response pulse.
// Optional feature macro: BRAM_DWC_DOWN_SKIP_EN -- write beats whose byte
// enables are all zero leave Bram_En_S low for that beat (timing unchanged).
module bram_dwc_down #(
    parameter int ADDR_BITW     = 32,
    parameter int MST_DATA_BITW = 96,
    parameter int SLV_DATA_BITW = 32
) (
    input  logic                     Clk_C,
    input  logic                     Rst_R,
    bram_dwc_down_if.slave           mst,
    output logic                     Bram_En_S,
    output logic [ADDR_BITW-1:0]     Bram_Addr_S,
    output logic [SLV_DATA_BITW/8-1:0] Bram_WrEn_S,
    output logic [SLV_DATA_BITW-1:0] Bram_Wr_D,
    input  logic [SLV_DATA_BITW-1:0] Bram_Rd_D
);
    localparam int RATIO     = MST_DATA_BITW / SLV_DATA_BITW;
    localparam int MST_BYTEW = MST_DATA_BITW / 8;
    localparam int SLV_BYTEW = SLV_DATA_BITW / 8;
    localparam int MST_BITO  = $clog2(MST_BYTEW);
    localparam int SLV_BITO  = $clog2(SLV_BYTEW);
    localparam int KW        = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(RATIO - 1);

    // Reject width combinations the beat slicing cannot represent.
    generate
        if (SLV_DATA_BITW <= 0 || SLV_DATA_BITW > MST_DATA_BITW ||
            (MST_DATA_BITW % SLV_DATA_BITW) != 0 || (SLV_DATA_BITW % 8) != 0 ||
            (SLV_BYTEW & (SLV_BYTEW - 1)) != 0) begin : g_bad_cfg
            $fatal(1, "bram_dwc_down: illegal MST_DATA_BITW/SLV_DATA_BITW combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e                   state_q,      state_d;
    logic [KW-1:0]            k_q,          k_d;
    logic [ADDR_BITW-1:0]     addr_q,       addr_d;
    logic                     we_q,         we_d;
    logic [MST_BYTEW-1:0]     wren_q,       wren_d;
    logic [MST_DATA_BITW-1:0] wdata_q,      wdata_d;
    logic                     bram_en_q,    bram_en_d;
    logic [ADDR_BITW-1:0]     bram_addr_q,  bram_addr_d;
    logic [SLV_BYTEW-1:0]     bram_wren_q,  bram_wren_d;
    logic [SLV_DATA_BITW-1:0] bram_wdata_q, bram_wdata_d;
    logic                     cap_vld_q,    cap_vld_d;
    logic [KW-1:0]            cap_idx_q,    cap_idx_d;
    logic [MST_DATA_BITW-1:0] rdata_q,      rdata_d;

    // Beat source: the live request on acceptance, the latched copy afterwards.
    logic                     issue;
    logic [KW-1:0]            beat_k;
    logic [ADDR_BITW-1:0]     src_addr;
    logic                     src_we;
    logic [MST_BYTEW-1:0]     src_wren;
    logic [MST_DATA_BITW-1:0] src_wdata;
    logic [SLV_BYTEW-1:0]     slice_wren;

    // Narrow byte address of beat k; wraps modulo 2^ADDR_BITW by truncation.
    function automatic logic [ADDR_BITW-1:0] beat_addr(input logic [ADDR_BITW-1:0] a,
                                                       input logic [KW-1:0]        k);
        logic [ADDR_BITW-1:0] word;
        word = (a >> MST_BITO) * ADDR_BITW'(RATIO) + ADDR_BITW'(k);
        return word << SLV_BITO;
    endfunction

    // Next-state logic, beat generation and read-data capture.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d      = state_q;
        k_d          = k_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wren_d       = wren_q;
        wdata_d      = wdata_q;
        bram_en_d    = 1'b0;
        bram_addr_d  = bram_addr_q;
        bram_wren_d  = '0;
        bram_wdata_d = '0;
        cap_vld_d    = 1'b0;
        cap_idx_d    = k_q;
        rdata_d      = rdata_q;
        issue        = 1'b0;
        beat_k       = '0;
        src_addr     = addr_q;
        src_we       = we_q;
        src_wren     = wren_q;
        src_wdata    = wdata_q;

        // The narrow BRAM answers one cycle after each read beat.
        if (cap_vld_q) begin
            rdata_d[int'(cap_idx_q) * SLV_DATA_BITW +: SLV_DATA_BITW] = Bram_Rd_D;
        end

        case (state_q)
            ST_IDLE: begin
                if (mst.Req_S) begin
                    addr_d    = mst.Addr_S;
                    we_d      = mst.We_S;
                    wren_d    = mst.WrEn_S;
                    wdata_d   = mst.Wr_D;
                    k_d       = '0;
                    state_d   = ST_ACCESS;
                    issue     = 1'b1;
                    beat_k    = '0;
                    src_addr  = mst.Addr_S;
                    src_we    = mst.We_S;
                    src_wren  = mst.WrEn_S;
                    src_wdata = mst.Wr_D;
                end
            end
            ST_ACCESS: begin
                cap_vld_d = !we_q;
                cap_idx_d = k_q;
                if (k_q == K_LAST) begin
                    state_d = ST_WAIT;
                end else begin
                    k_d    = k_q + 1'b1;
                    issue  = 1'b1;
                    beat_k = k_q + 1'b1;
                end
            end
            ST_WAIT: state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        slice_wren = src_wren[int'(beat_k) * SLV_BYTEW +: SLV_BYTEW];

        // Bram_* outputs are registered, so the beat shown in cycle k is prepared one edge earlier.
        if (issue) begin
            bram_addr_d = beat_addr(src_addr, beat_k);
            if (src_we) begin
                bram_wren_d  = slice_wren;
                bram_wdata_d = src_wdata[int'(beat_k) * SLV_DATA_BITW +: SLV_DATA_BITW];
            end
`ifdef BRAM_DWC_DOWN_SKIP_EN
            bram_en_d = !(src_we && (slice_wren == '0));
`else
            bram_en_d = 1'b1;
`endif
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge Clk_C) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (Rst_R) begin
            // NOTE: only control and output flops need reset; the latched request is always reloaded on acceptance.
            state_q      <= ST_IDLE;
            k_q          <= '0;
            bram_en_q    <= 1'b0;
            bram_addr_q  <= '0;
            bram_wren_q  <= '0;
            bram_wdata_q <= '0;
            cap_vld_q    <= 1'b0;
            cap_idx_q    <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            bram_en_q    <= bram_en_d;
            bram_addr_q  <= bram_addr_d;
            bram_wren_q  <= bram_wren_d;
            bram_wdata_q <= bram_wdata_d;
            cap_vld_q    <= cap_vld_d;
            cap_idx_q    <= cap_idx_d;
            rdata_q      <= rdata_d;
        end
    end

    // Latched copy of the accepted request.
    always_ff @(posedge Clk_C) begin
        addr_q  <= addr_d;
        we_q    <= we_d;
        wren_q  <= wren_d;
        wdata_q <= wdata_d;
    end

    assign mst.Gnt_S      = (state_q == ST_IDLE);
    assign mst.RspValid_S = (state_q == ST_RESP);
    assign mst.Rd_D       = rdata_q;
    assign Bram_En_S      = bram_en_q;
    assign Bram_Addr_S    = bram_addr_q;
    assign Bram_WrEn_S    = bram_wren_q;
    assign Bram_Wr_D      = bram_wdata_q;
endmodule

// File: tb/tb_bram_dwc_down.sv
// Self-checking bench for bram_dwc_down at default widths (RATIO=3).
// Expected beats and read responses are queued when a request is driven and
// popped when the DUT presents them; a behavioural 32-bit BRAM closes the loop.
module tb_bram_dwc_down;
    localparam int AW = 32;
    localparam int MW = 96;
    localparam int SW = 32;

    typedef struct {
        logic [31:0] addr;
        logic        en;
        logic [3:0]  wren;
        logic [31:0] wdata;
    } beat_t;

    logic        Clk_C = 1'b0;
    logic        Rst_R;
    logic        Bram_En_S;
    logic [31:0] Bram_Addr_S;
    logic [3:0]  Bram_WrEn_S;
    logic [31:0] Bram_Wr_D;
    logic [31:0] Bram_Rd_D;

    bram_dwc_down_if #(.ADDR_BITW(AW), .MST_DATA_BITW(MW)) mst_if ();

    bram_dwc_down #(.ADDR_BITW(AW), .MST_DATA_BITW(MW), .SLV_DATA_BITW(SW)) dut (
        .Clk_C       (Clk_C),
        .Rst_R       (Rst_R),
        .mst         (mst_if),
        .Bram_En_S   (Bram_En_S),
        .Bram_Addr_S (Bram_Addr_S),
        .Bram_WrEn_S (Bram_WrEn_S),
        .Bram_Wr_D   (Bram_Wr_D),
        .Bram_Rd_D   (Bram_Rd_D)
    );

    always #5 Clk_C = ~Clk_C;

    // Behavioural narrow BRAM: read-first, one-cycle read latency.
    logic [31:0] bram_mem [64];
    logic        mem_clr;
    always @(posedge Clk_C) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) bram_mem[i] <= '0;
        end else if (Bram_En_S) begin
            for (int j = 0; j < 4; j++)
                if (Bram_WrEn_S[j]) bram_mem[Bram_Addr_S[7:2]][j*8 +: 8] <= Bram_Wr_D[j*8 +: 8];
            Bram_Rd_D <= bram_mem[Bram_Addr_S[7:2]];
        end
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_mem [64];
    beat_t       beat_q [$];
    logic [95:0] rsp_q [$];
    logic [95:0] exp_rd;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic beat_en_exp(input logic we, input logic [3:0] be);
`ifdef BRAM_DWC_DOWN_SKIP_EN
        return !(we && (be == 4'h0));
`else
        return 1'b1;
`endif
    endfunction

    // Reference narrow word index: three 32-bit words per 16-byte wide slot.
    function automatic logic [5:0] word_idx(input logic [31:0] a, input int k);
        logic [31:0] w;
        w = (a / 32'd16) * 32'd3 + 32'(k);
        return w[5:0];
    endfunction

    function automatic logic [95:0] rd_exp(input logic [31:0] a);
        return {exp_mem[word_idx(a, 2)], exp_mem[word_idx(a, 1)], exp_mem[word_idx(a, 0)]};
    endfunction

    // Queue the expected beats (and read response) of one wide request.
    task automatic push_expect(input logic [31:0] a, input logic we, input logic [11:0] be,
                               input logic [95:0] wd);
        beat_t b;
        for (int k = 0; k < 3; k++) begin
            b.addr  = {24'h0, word_idx(a, k), 2'b00};
            b.wren  = we ? be[k*4 +: 4] : 4'h0;
            b.wdata = we ? wd[k*32 +: 32] : 32'h0;
            b.en    = beat_en_exp(we, b.wren);
            beat_q.push_back(b);
            if (we)
                for (int j = 0; j < 4; j++)
                    if (be[k*4 + j]) exp_mem[word_idx(a, k)][j*8 +: 8] = wd[k*32 + j*8 +: 8];
        end
        if (!we) rsp_q.push_back(rd_exp(a));
    endtask

    // Full transaction; entered and left just after a falling edge in IDLE.
    task automatic run_txn(input string tag, input logic [31:0] a, input logic we,
                           input logic [11:0] be, input logic [95:0] wd);
        beat_t b;
        check({tag, "_gnt_idle"}, mst_if.Gnt_S, 1'b1);
        mst_if.Req_S = 1'b1; mst_if.Addr_S = a; mst_if.We_S = we;
        mst_if.WrEn_S = be; mst_if.Wr_D = wd;
        push_expect(a, we, be, wd);
        @(negedge Clk_C);
        // Scramble the bus to prove the request was latched.
        mst_if.Req_S = 1'b0; mst_if.Addr_S = $urandom; mst_if.We_S = ~we;
        mst_if.WrEn_S = 12'($urandom); mst_if.Wr_D = {$urandom, $urandom, $urandom};
        for (int k = 0; k < 3; k++) begin
            b = beat_q.pop_front();
            check({tag, "_gnt_busy"}, mst_if.Gnt_S, 1'b0);
            check({tag, "_en"},    Bram_En_S,   b.en);
            check({tag, "_addr"},  Bram_Addr_S, b.addr);
            check({tag, "_wren"},  Bram_WrEn_S, b.wren);
            check({tag, "_wdata"}, Bram_Wr_D,   b.wdata);
            check({tag, "_rsp_early"}, mst_if.RspValid_S, 1'b0);
            @(negedge Clk_C);
        end
        check({tag, "_wait_en"},   Bram_En_S, 1'b0);
        check({tag, "_wait_wren"}, Bram_WrEn_S, 4'h0);
        check({tag, "_wait_rsp"},  mst_if.RspValid_S, 1'b0);
        check({tag, "_wait_gnt"},  mst_if.Gnt_S, 1'b0);
        @(negedge Clk_C);
        check({tag, "_rsp"},      mst_if.RspValid_S, 1'b1);
        check({tag, "_rsp_gnt"},  mst_if.Gnt_S, 1'b0);
        if (!we) exp_rd = rsp_q.pop_front();
        check({tag, "_rd"},       mst_if.Rd_D, exp_rd);
        @(negedge Clk_C);
        check({tag, "_rsp_once"}, mst_if.RspValid_S, 1'b0);
    endtask

    initial begin
        exp_rd = '0;
        for (int i = 0; i < 64; i++) exp_mem[i] = '0;
        Rst_R = 1'b1; mem_clr = 1'b1;
        mst_if.Req_S = 1'b0; mst_if.Addr_S = '0; mst_if.We_S = 1'b0;
        mst_if.WrEn_S = '0; mst_if.Wr_D = '0;
        repeat (2) @(negedge Clk_C);

        // Reset state.
        check("rst_gnt",   mst_if.Gnt_S, 1'b1);
        check("rst_rsp",   mst_if.RspValid_S, 1'b0);
        check("rst_rd",    mst_if.Rd_D, 96'h0);
        check("rst_en",    Bram_En_S, 1'b0);
        check("rst_addr",  Bram_Addr_S, 32'h0);
        check("rst_wren",  Bram_WrEn_S, 4'h0);
        check("rst_wdata", Bram_Wr_D, 32'h0);
        Rst_R = 1'b0; mem_clr = 1'b0;
        @(negedge Clk_C);

        // 1. Full write; 2. read back and hold.
        run_txn("full_wr", 32'h20, 1'b1, 12'hFFF, 96'hCCCCCCCC_BBBBBBBB_AAAAAAAA);
        check("wr_addr_hold", Bram_Addr_S, 32'h20);
        run_txn("rd_back", 32'h20, 1'b0, 12'h000, 96'h0);
        check("rd_back_const", mst_if.Rd_D, 96'hCCCCCCCC_BBBBBBBB_AAAAAAAA);
        repeat (3) begin
            @(negedge Clk_C);
            check("rd_hold", mst_if.Rd_D, exp_rd);
        end

        // 3. Partial write: only the middle word; Rd_D must not move.
        run_txn("part_wr", 32'h30, 1'b1, 12'h0F0, 96'h33333333_22222222_11111111);

        // 4. Back-to-back reads with Req_S held high.
        check("b2b_gnt0", mst_if.Gnt_S, 1'b1);
        mst_if.Req_S = 1'b1; mst_if.We_S = 1'b0; mst_if.Addr_S = 32'h20;
        rsp_q.push_back(rd_exp(32'h20));
        rsp_q.push_back(rd_exp(32'h30));
        for (int c = 1; c <= 12; c++) begin
            @(negedge Clk_C);
            if (c == 1) mst_if.Addr_S = 32'h30;
            if (c == 7) mst_if.Req_S = 1'b0;
            check($sformatf("b2b_gnt_c%0d", c), mst_if.Gnt_S, (c == 6 || c == 12));
            check($sformatf("b2b_rsp_c%0d", c), mst_if.RspValid_S, (c == 5 || c == 11));
            if (c == 5 || c == 11) begin
                exp_rd = rsp_q.pop_front();
                check($sformatf("b2b_rd_c%0d", c), mst_if.Rd_D, exp_rd);
            end
        end

        // 5. Reset during beat 1 of a write.
        check("abort_gnt_idle", mst_if.Gnt_S, 1'b1);
        mst_if.Req_S = 1'b1; mst_if.We_S = 1'b1; mst_if.Addr_S = 32'h40;
        mst_if.WrEn_S = 12'hFFF; mst_if.Wr_D = 96'h99999999_88888888_77777777;
        @(negedge Clk_C);
        mst_if.Req_S = 1'b0;
        check("abort_beat0_en", Bram_En_S, 1'b1);
        @(negedge Clk_C);
        check("abort_beat1_en",   Bram_En_S, 1'b1);
        check("abort_beat1_addr", Bram_Addr_S, 32'h34);
        Rst_R = 1'b1;
        @(negedge Clk_C);
        Rst_R = 1'b0;
        exp_mem[12] = 32'h77777777;
        exp_mem[13] = 32'h88888888;
        exp_rd = '0;
        check("abort_en",   Bram_En_S, 1'b0);
        check("abort_gnt",  mst_if.Gnt_S, 1'b1);
        check("abort_rd",   mst_if.Rd_D, 96'h0);
        check("abort_addr", Bram_Addr_S, 32'h0);
        for (int c = 0; c < 6; c++) begin
            check("abort_no_rsp", mst_if.RspValid_S, 1'b0);
            @(negedge Clk_C);
        end
        run_txn("abort_rd_back", 32'h40, 1'b0, 12'h000, 96'h0);

        // 6. Unaligned address maps to the same narrow words as 0x20.
        run_txn("unaligned", 32'h2C, 1'b0, 12'h000, 96'h0);
        check("unaligned_const", mst_if.Rd_D, 96'hCCCCCCCC_BBBBBBBB_AAAAAAAA);

        check("queues_empty", 96'(beat_q.size() + rsp_q.size()), 96'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
